// File: rtl/usb_rx_pkg.sv
// ----------------------------------------------------------------------------
// usb_rx_pkg
// Shared definitions for the USB receive path: SYNC field description,
// bit-stuffing run length, the unstuffer state encoding and the control
// word the unstuffer FSM hands to its datapath.
// These constants are shared with the transmit-side bit stuffer and the
// tests, so they must stay in sync with the line protocol.
// ----------------------------------------------------------------------------
package usb_rx_pkg;

   // Consecutive 1s after which the next bit on the wire is a stuffed 0.
   localparam int MAX_ONES = 6;

   // SYNC field length and pattern in arrival order (bit[0] arrives first):
   // seven 0s followed by a single 1.
   localparam int               SYNC_LEN     = 8;
   localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'b1000_0000;

   // Counter widths: sync_cnt indexes SYNC_PATTERN, ones_cnt counts 0..MAX_ONES.
   localparam int SYNC_CNT_W = 3;
   localparam int ONES_CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      DATA  = 2'd2,
      ERROR = 2'd3
   } rx_unstuff_state_t;

   // One-cycle control strobes decoded by the FSM for the datapath.
   typedef struct packed {
      logic start;       // first bit of a new packet (from IDLE)
      logic sync_fail;   // SYNC mismatch or packet ended inside SYNC
      logic sync_adv;    // SYNC bit matched, more SYNC bits to come
      logic enter_data;  // final SYNC bit matched, payload follows
      logic emit;        // payload bit goes out with out_valid
      logic drop_stuff;  // stuffed 0 consumed silently
      logic stuff_fail;  // 1 seen where a stuffed 0 was required
      logic busy_next;   // next state is SYNC or DATA
   } unstuff_ctrl_t;

   // Expected SYNC bit for a given arrival position.
   function automatic logic sync_bit(input logic [SYNC_CNT_W-1:0] idx);
      return SYNC_PATTERN[idx];
   endfunction

endpackage

// File: rtl/bit_unstuffer_fsm.sv
// ----------------------------------------------------------------------------
// bit_unstuffer_fsm
// State register and next-state / control decode for the bit unstuffer.
// The datapath (counters and output registers) lives in bit_unstuffer and
// is steered by the ctrl strobes produced here.
//
// Ports
//   clock        in   system clock, state changes on posedge
//   reset        in   asynchronous active-high reset, forces IDLE
//   nrzi_sending in   a decoded bit is present this cycle
//   in_bit       in   decoded bit
//   sync_bit_ok  in   in_bit equals the SYNC bit expected at this position
//   sync_last    in   current SYNC position is the final SYNC bit
//   stuff_slot   in   MAX_ONES 1s seen, this bit must be a stuffed 0
//   state        out  current state (also serves as debug visibility)
//   ctrl         out  decoded control strobes for this cycle
// ----------------------------------------------------------------------------
module bit_unstuffer_fsm
   import usb_rx_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              nrzi_sending,
   input  logic              in_bit,
   input  logic              sync_bit_ok,
   input  logic              sync_last,
   input  logic              stuff_slot,
   output rx_unstuff_state_t state,
   output unstuff_ctrl_t     ctrl
);

   rx_unstuff_state_t next_state;

   always_comb begin
      ctrl       = '0;
      next_state = state;
      unique case (state)
         IDLE: begin
            if (nrzi_sending) begin
               ctrl.start = 1'b1;
               // The first SYNC bit is checked like every other SYNC bit.
               if (sync_bit_ok) begin
                  next_state = SYNC;
               end else begin
                  ctrl.sync_fail = 1'b1;
                  next_state     = ERROR;
               end
            end
         end
         SYNC: begin
            if (!nrzi_sending) begin
               // Packet ended before SYNC completed: a short packet.
               ctrl.sync_fail = 1'b1;
               next_state     = IDLE;
            end else if (!sync_bit_ok) begin
               ctrl.sync_fail = 1'b1;
               next_state     = ERROR;
            end else if (sync_last) begin
               ctrl.enter_data = 1'b1;
               next_state      = DATA;
            end else begin
               ctrl.sync_adv = 1'b1;
            end
         end
         DATA: begin
            if (!nrzi_sending) begin
               // Ending on a pending stuff slot is a legal packet end.
               next_state = IDLE;
            end else if (stuff_slot) begin
               if (in_bit) begin
                  ctrl.stuff_fail = 1'b1;
                  next_state      = ERROR;
               end else begin
                  ctrl.drop_stuff = 1'b1;
               end
            end else begin
               ctrl.emit = 1'b1;
            end
         end
         ERROR: begin
            if (!nrzi_sending) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      ctrl.busy_next = (next_state == SYNC) || (next_state == DATA);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

endmodule

// File: rtl/bit_unstuffer.sv
// ----------------------------------------------------------------------------
// bit_unstuffer
// Receive-path stage after the NRZI decoder. Checks and strips the SYNC
// field, removes the stuffed 0 following every run of MAX_ONES 1s, and
// emits payload bits with a per-bit valid strobe. All outputs are
// registered: a bit sampled on edge N is visible after edge N.
//
// Ports
//   clock            in   system clock
//   reset            in   asynchronous active-high reset
//   in_bit           in   decoded bit, meaningful while nrzi_sending=1
//   nrzi_sending     in   high for every cycle carrying a decoded bit
//   out_bit          out  unstuffed payload bit (0 when out_valid=0)
//   out_valid        out  out_bit is a payload bit this cycle
//   unstuff_sending  out  packet in progress (SYNC or DATA)
//   sync_error       out  sticky SYNC error for the current/last packet
//   stuff_error      out  sticky stuffing error for the current/last packet
// ----------------------------------------------------------------------------
module bit_unstuffer
   import usb_rx_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic in_bit,
   input  logic nrzi_sending,
   output logic out_bit,
   output logic out_valid,
   output logic unstuff_sending,
   output logic sync_error,
   output logic stuff_error
);

   rx_unstuff_state_t     state;
   unstuff_ctrl_t         ctrl;
   logic [SYNC_CNT_W-1:0] sync_cnt;
   logic [SYNC_CNT_W-1:0] sync_idx;
   logic [ONES_CNT_W-1:0] ones_cnt;
   logic                  sync_bit_ok;
   logic                  sync_last;
   logic                  stuff_slot;

   // In IDLE the incoming bit is always SYNC position 0, regardless of
   // whatever sync_cnt was left holding.
   assign sync_idx    = (state == IDLE) ? '0 : sync_cnt;
   assign sync_bit_ok = (in_bit == sync_bit(sync_idx));
   assign sync_last   = (sync_cnt == SYNC_CNT_W'(SYNC_LEN - 1));
   assign stuff_slot  = (ones_cnt == ONES_CNT_W'(MAX_ONES));

   bit_unstuffer_fsm u_fsm (
      .clock        (clock),
      .reset        (reset),
      .nrzi_sending (nrzi_sending),
      .in_bit       (in_bit),
      .sync_bit_ok  (sync_bit_ok),
      .sync_last    (sync_last),
      .stuff_slot   (stuff_slot),
      .state        (state),
      .ctrl         (ctrl)
   );

   // SYNC position counter: 1 after the first SYNC bit, cleared once the
   // SYNC field is left for any reason.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_cnt <= '0;
      end else if (ctrl.start) begin
         sync_cnt <= SYNC_CNT_W'(1);
      end else if (ctrl.sync_adv) begin
         sync_cnt <= sync_cnt + SYNC_CNT_W'(1);
      end else begin
         sync_cnt <= '0;
      end
   end

   // Run-of-ones counter. SYNC ends in a 1, so the run starts at 1 when
   // payload begins. It never exceeds MAX_ONES: reaching it makes the next
   // bit a stuff slot, which either clears it or ends the packet in ERROR.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ones_cnt <= '0;
      end else if (ctrl.start || ctrl.drop_stuff) begin
         ones_cnt <= '0;
      end else if (ctrl.enter_data) begin
         ones_cnt <= ONES_CNT_W'(1);
      end else if (ctrl.emit) begin
         ones_cnt <= in_bit ? (ones_cnt + ONES_CNT_W'(1)) : '0;
      end
   end

   // Payload output registers. out_bit is forced to 0 whenever no payload
   // bit is being presented.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_bit         <= 1'b0;
         out_valid       <= 1'b0;
         unstuff_sending <= 1'b0;
      end else begin
         out_bit         <= ctrl.emit & in_bit;
         out_valid       <= ctrl.emit;
         unstuff_sending <= ctrl.busy_next;
      end
   end

   // Sticky error flags: cleared only at the start of the next packet.
   // A first-bit SYNC mismatch is reported on the same edge that starts
   // the packet, so it takes priority over the clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_error  <= 1'b0;
         stuff_error <= 1'b0;
      end else begin
         if (ctrl.start) begin
            sync_error <= ctrl.sync_fail;
         end else if (ctrl.sync_fail) begin
            sync_error <= 1'b1;
         end

         if (ctrl.start) begin
            stuff_error <= 1'b0;
         end else if (ctrl.stuff_fail) begin
            stuff_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bit_unstuffer.sv
// ----------------------------------------------------------------------------
// tb_bit_unstuffer
// Directed scenarios for bit_unstuffer. Payload bits are pushed into an
// expected queue by a small stuffing model when driven; a negedge monitor
// pops and compares whenever the DUT raises out_valid.
// Inputs change 1 time unit after the falling edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_bit_unstuffer;
   import usb_rx_pkg::*;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;
   logic in_bit;
   logic nrzi_sending;
   logic out_bit;
   logic out_valid;
   logic unstuff_sending;
   logic sync_error;
   logic stuff_error;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   bit_unstuffer dut (
      .clock           (clock),
      .reset           (reset),
      .in_bit          (in_bit),
      .nrzi_sending    (nrzi_sending),
      .out_bit         (out_bit),
      .out_valid       (out_valid),
      .unstuff_sending (unstuff_sending),
      .sync_error      (sync_error),
      .stuff_error     (stuff_error)
   );

   // ---------------- scoreboard ----------------
   logic [0:0] exp_q[$];
   int         n_total = 0;
   int         n_pass  = 0;
   int         n_fail  = 0;
   int         m_ones  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
               check("out_bit", 32'(out_bit), 32'(exp_q.pop_front()));
            end
         end else begin
            check("out_bit_zero_when_invalid", 32'(out_bit), 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_bit(input logic b);
      in_bit       = b;
      nrzi_sending = 1'b1;
      @(negedge clock);
      #1;
   endtask

   task automatic end_packet();
      nrzi_sending = 1'b0;
      in_bit       = 1'($urandom_range(0, 1));
      @(negedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      nrzi_sending = 1'b0;
      in_bit       = 1'b0;
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic send_sync();
      for (int i = 0; i < SYNC_LEN; i++) send_bit(SYNC_PATTERN[i]);
      m_ones = 1;
   endtask

   // Reference stuffing model: decides whether a data bit is payload or a
   // stuff slot, queues expected payload, then drives the bit.
   task automatic send_data(input logic b);
      if (m_ones == MAX_ONES) begin
         if (!b) m_ones = 0;
      end else begin
         exp_q.push_back(b);
         m_ones = b ? m_ones + 1 : 0;
      end
      send_bit(b);
   endtask

   // Sends n bits written left-to-right (v[n-1] first).
   task automatic send_vec(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_data(v[i]);
   endtask

   // Random payload biased toward 1s; inserts the stuffed 0 where needed.
   task automatic send_random(input int n);
      for (int i = 0; i < n; i++) begin
         if (m_ones == MAX_ONES) send_data(1'b0);
         else send_data(1'($urandom_range(0, 3) != 0));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset        = 1'b1;
      in_bit       = 1'b0;
      nrzi_sending = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("rst_out_bit", 32'(out_bit), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sending", 32'(unstuff_sending), 32'd0);
      check("rst_sync_error", 32'(sync_error), 32'd0);
      check("rst_stuff_error", 32'(stuff_error), 32'd0);
      reset = 1'b0;
      idle(2);

      // 1: clean packet, payload 1010_0011
      send_bit(SYNC_PATTERN[0]);
      check("t1_sending_first_sync", 32'(unstuff_sending), 32'd1);
      for (int i = 1; i < SYNC_LEN; i++) send_bit(SYNC_PATTERN[i]);
      m_ones = 1;
      check("t1_valid_low_in_sync", 32'(out_valid), 32'd0);
      send_vec(16'b1010_0011, 8);
      check("t1_sending_in_data", 32'(unstuff_sending), 32'd1);
      end_packet();
      check("t1_sending_drop", 32'(unstuff_sending), 32'd0);
      check("t1_valid_drop", 32'(out_valid), 32'd0);
      check("t1_sync_error", 32'(sync_error), 32'd0);
      check("t1_stuff_error", 32'(stuff_error), 32'd0);
      check("t1_drained", 32'(exp_q.size()), 32'd0);
      idle(2);

      // 2: SYNC's 1 plus five payload 1s -> stuffed 0 dropped, then 1
      send_sync();
      send_vec(16'b1111_1010_011, 11);
      check("t2_stuff_error", 32'(stuff_error), 32'd0);
      end_packet();
      check("t2_drained", 32'(exp_q.size()), 32'd0);
      idle(2);

      // 3: 1 in stuff slot -> stuff_error, no further output
      send_sync();
      send_vec(16'b11111, 5);
      send_data(1'b1);
      check("t3_stuff_error_set", 32'(stuff_error), 32'd1);
      check("t3_valid_low", 32'(out_valid), 32'd0);
      check("t3_sending_low", 32'(unstuff_sending), 32'd0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
      check("t3_stuff_error_hold", 32'(stuff_error), 32'd1);
      end_packet();
      idle(3);
      check("t3_stuff_error_after_pkt", 32'(stuff_error), 32'd1);
      check("t3_drained", 32'(exp_q.size()), 32'd0);

      // 4: SYNC 0000_0101 -> sync_error after the 6th bit; also clears stuff_error
      send_bit(1'b0);
      check("t4_stuff_error_cleared", 32'(stuff_error), 32'd0);
      check("t4_sync_error_start", 32'(sync_error), 32'd0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      check("t4_sync_error_5th", 32'(sync_error), 32'd0);
      send_bit(1'b1);
      check("t4_sync_error_6th", 32'(sync_error), 32'd1);
      check("t4_sending_low", 32'(unstuff_sending), 32'd0);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)));
      end_packet();
      idle(2);
      check("t4_sync_error_hold", 32'(sync_error), 32'd1);

      // short packet: ends inside SYNC
      send_bit(1'b0);
      check("short_sync_error_cleared", 32'(sync_error), 32'd0);
      send_bit(1'b0);
      send_bit(1'b0);
      end_packet();
      check("short_sync_error", 32'(sync_error), 32'd1);
      check("short_sending", 32'(unstuff_sending), 32'd0);
      idle(2);

      // 5: packet ends on a pending stuff slot -> not an error
      send_sync();
      send_vec(16'b0111111, 7);
      end_packet();
      check("t5_stuff_error", 32'(stuff_error), 32'd0);
      check("t5_sync_error", 32'(sync_error), 32'd0);
      check("t5_sending", 32'(unstuff_sending), 32'd0);
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      idle(2);

      // 6: reset mid-DATA, then a random stuffed packet
      send_sync();
      send_vec(16'b1101, 4);
      check("t6_valid_before_rst", 32'(out_valid), 32'd1);
      reset        = 1'b1;
      nrzi_sending = 1'b0;
      #1;
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_out_bit", 32'(out_bit), 32'd0);
      check("t6_rst_sending", 32'(unstuff_sending), 32'd0);
      check("t6_rst_sync_error", 32'(sync_error), 32'd0);
      check("t6_rst_stuff_error", 32'(stuff_error), 32'd0);
      @(negedge clock);
      #1;
      reset = 1'b0;
      idle(2);
      send_sync();
      send_random(48);
      check("t6_stuff_error", 32'(stuff_error), 32'd0);
      end_packet();
      check("t6_sync_error", 32'(sync_error), 32'd0);
      check("t6_drained", 32'(exp_q.size()), 32'd0);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
